// File: rtl/imm_decode_buf.sv
// Decodes MIPS opcodes into immediate-extender controls (imm, EOp, rt) behind a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid; outputs driven directly from the main register.
// Backpressure: in_ready is registered and drops only when both entries are full; out_ready never reaches in_ready combinationally.
// Optional feature macro: ILLEGAL_DROP_EN (accept but discard undecodable opcodes; illegal tied to 0).
module imm_decode_buf #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      imm,
    output logic [1:0]       EOp,
    output logic [4:0]       rt,
    output logic             illegal,
    output logic [CNT_W-1:0] acc_cnt
);

    // One decoded buffer entry.
    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic [4:0]  rt;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // The buffer is hard-wired as main + skid; any other depth is meaningless.
    generate
        if (DEPTH != 2) begin : g_bad_depth
            $error("imm_decode_buf supports DEPTH == 2 only");
        end
    endgenerate

    state_t             state_q;
    state_t             state_d;
    entry_t             main_q;
    entry_t             skid_q;
    entry_t             dec;
    logic               dec_bad;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   acc_cnt_q;
    logic               accept;
    logic               emit;
    logic               wr;
    logic               load_main;
    logic               load_skid;
    logic               skid_to_main;

    // rs field is not needed by the extender.
    logic               unused_rs;
    assign unused_rs = ^in_instr[25:21];

    // Decode the incoming word; the result is captured per entry at accept time.
    always_comb begin
        dec      = '0;
        dec_bad  = 1'b0;
        dec.imm  = in_instr[15:0];
        dec.rt   = in_instr[20:16];
        case (in_instr[31:26])
            6'b001000, 6'b001001, 6'b100011, 6'b101011: dec.eop = 2'b00;
            6'b001101:                                  dec.eop = 2'b01;
            6'b001111:                                  dec.eop = 2'b10;
            6'b000100:                                  dec.eop = 2'b11;
            default: begin
                dec.eop = 2'b00;
                dec_bad = 1'b1;
            end
        endcase
`ifdef ILLEGAL_DROP_EN
        dec.illegal = 1'b0;
`else
        dec.illegal = dec_bad;
`endif
    end

    assign accept = in_valid && in_ready_q;
    assign emit   = out_valid_q && out_ready;

    // Writes into the buffer: every accepted word, unless dropping undecodable ones.
`ifdef ILLEGAL_DROP_EN
    assign wr = accept && !dec_bad;
`else
    assign wr = accept;
`endif

    // Occupancy next-state and datapath steering.
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (wr) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (wr && emit) begin
                    load_main = 1'b1;
                end else if (wr) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_d      = ST_ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State register plus registered handshake outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Main and skid entry registers; main only changes on load or skid promotion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= dec;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    // Accepted-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_cnt_q <= '0;
        end else if (accept) begin
            acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign imm       = main_q.imm;
    assign EOp       = main_q.eop;
    assign rt        = main_q.rt;
    assign illegal   = main_q.illegal;
    assign acc_cnt   = acc_cnt_q;

endmodule

// File: tb/tb_imm_decode_buf.sv
// Directed bench for imm_decode_buf: reset, decode sweep, backpressure, streaming, illegal, wrap.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants and a bench-side word counter.
module tb_imm_decode_buf;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic [4:0]  rt;
    logic        illegal;
    logic [15:0] acc_cnt;

    int checks = 0;
    int errors = 0;

    imm_decode_buf #(.CNT_W(16), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .EOp       (eop),
        .rt        (rt),
        .illegal   (illegal),
        .acc_cnt   (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] w;

        // Reset held for two cycles with a valid word pending.
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h3C01_FFF6;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_acc_cnt",   32'(acc_cnt),   0);
        chk("rst_imm",       32'(imm),       0);
        chk("rst_eop",       32'(eop),       0);
        chk("rst_rt",        32'(rt),        0);
        chk("rst_illegal",   32'(illegal),   0);

        // Decode sweep, back-to-back with out_ready=1.
        reset = 1'b1;
        tick();                                   // lui accepted
        chk("lui_valid", 32'(out_valid), 1);
        chk("lui_eop",   32'(eop),       2);
        chk("lui_imm",   32'(imm),       32'hFFF6);
        chk("lui_rt",    32'(rt),        1);
        chk("first_cnt", 32'(acc_cnt),   1);
        in_instr = 32'h3402_FFF6;
        tick();
        chk("ori_eop", 32'(eop), 1);
        chk("ori_rt",  32'(rt),  2);
        in_instr = 32'h1000_FFF6;
        tick();
        chk("beq_eop", 32'(eop), 3);
        chk("beq_imm", 32'(imm), 32'hFFF6);
        in_instr = 32'h2003_FFF6;
        tick();
        chk("addi_eop",     32'(eop),     0);
        chk("addi_rt",      32'(rt),      3);
        chk("addi_illegal", 32'(illegal), 0);
        chk("sweep_cnt",    32'(acc_cnt), 4);
        chk("sweep_rdy",    32'(in_ready), 1);
        in_valid = 1'b0;
        tick();
        chk("sweep_drain_valid", 32'(out_valid), 0);

        // Backpressure from a fresh reset: three words, downstream stalled.
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h8C25_1234;                // lw rt=5
        tick();
        chk("bp1_rdy", 32'(in_ready),  1);
        chk("bp1_imm", 32'(imm),       32'h1234);
        chk("bp1_rt",  32'(rt),        5);
        in_instr = 32'h3426_ABCD;                 // ori rt=6
        tick();
        chk("bp2_rdy",   32'(in_ready), 0);
        chk("bp2_hold",  32'(imm),      32'h1234);
        in_instr = 32'h3C07_5555;                 // lui rt=7, held upstream
        tick();
        chk("bp3_rdy",   32'(in_ready), 0);
        chk("bp3_hold",  32'(imm),      32'h1234);
        chk("bp3_eop",   32'(eop),      0);
        chk("bp3_cnt",   32'(acc_cnt),  2);
        out_ready = 1'b1;
        tick();                                   // skid promoted, no accept
        chk("bpd1_imm", 32'(imm),      32'hABCD);
        chk("bpd1_eop", 32'(eop),      1);
        chk("bpd1_rt",  32'(rt),       6);
        chk("bpd1_rdy", 32'(in_ready), 1);
        chk("bpd1_cnt", 32'(acc_cnt),  2);
        tick();                                   // third word accepted
        chk("bpd2_imm", 32'(imm), 32'h5555);
        chk("bpd2_eop", 32'(eop), 2);
        chk("bpd2_rt",  32'(rt),  7);
        in_valid = 1'b0;
        tick();
        chk("bp_end_valid", 32'(out_valid), 0);
        chk("bp_end_cnt",   32'(acc_cnt),   3);

        // Sustained streaming: one addiu per cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = 32'h2400_0000 | (32'(i) << 16) | (32'h0100 + 32'(i));
            in_instr = w;
            tick();
            chk("strm_valid", 32'(out_valid), 1);
            chk("strm_imm",   32'(imm),       32'h0100 + 32'(i));
            chk("strm_rt",    32'(rt),        32'(i));
            chk("strm_rdy",   32'(in_ready),  1);
        end
        in_valid = 1'b0;
        tick();
        chk("strm_end_valid", 32'(out_valid), 0);
        chk("strm_end_cnt",   32'(acc_cnt),   13);

        // Undecodable opcode.
        in_valid = 1'b1;
        in_instr = 32'hFC00_0000;
        tick();
        in_valid = 1'b0;
        chk("ill_cnt", 32'(acc_cnt), 14);
`ifdef ILLEGAL_DROP_EN
        chk("ill_drop_valid", 32'(out_valid), 0);
`else
        chk("ill_valid",   32'(out_valid), 1);
        chk("ill_illegal", 32'(illegal),   1);
        chk("ill_eop",     32'(eop),       0);
`endif
        tick();
        chk("ill_end_valid", 32'(out_valid), 0);

        // Counter wrap after 65535 accepts from reset.
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h2001_0001;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        chk("cnt_max", 32'(acc_cnt), 32'hFFFF);
        tick();
        chk("cnt_wrap", 32'(acc_cnt), 0);

        // Fill both entries, then reset mid-transfer.
        out_ready = 1'b0;
        in_instr  = 32'h3C09_7777;
        tick();
        chk("full_rdy", 32'(in_ready), 0);
        chk("full_cnt", 32'(acc_cnt),  1);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        reset     = 1'b1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_rdy",   32'(in_ready),  1);
        chk("midrst_cnt",   32'(acc_cnt),   0);
        out_ready = 1'b1;
        tick();
        chk("midrst_lost", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_buf.md
Name: imm_decode_buf

Overview:
- Upstream neighbour of the immediate extender (ext).
- Accepts 32-bit MIPS instruction words over a valid/ready handshake and decodes opcode into the extender's imm[15:0] and EOp[1:0] controls plus the rt field.
- Holds results in a 2-entry skid buffer, so neither side's stall creates a combinational ready path.
- Counts accepted instructions for bench and debug visibility.

Parameters:
- CNT_W, 16, width of the accepted-instruction counter.
- DEPTH, 2, buffer depth; fixed at 2 (main and skid). Other values are unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 resets.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  buffer can accept; registered output.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded entry available at head.
- out_ready  in  1  downstream (ext stage) consumes head.
- imm  out  16  in_instr[15:0] of head entry.
- EOp  out  2  extender op of head entry.
- rt  out  5  in_instr[20:16] of head entry.
- illegal  out  1  head opcode not in decode table.
- acc_cnt  out  CNT_W  number of accepted instructions, mod 2^CNT_W.

Behaviour:
- Reset (reset==0 at a clk edge) clears all state:
  - out_valid=0, in_ready=1, imm=0, EOp=0, rt=0, illegal=0, acc_cnt=0.
  - Both entries are invalidated.
  - Reset mid-transfer discards buffered entries without emitting them.
- Accept: in_valid && in_ready at a rising edge. Acceptance increments acc_cnt by 1 and wraps from all-ones to 0.
- Emit: out_valid && out_ready at a rising edge.
- Decode is applied at accept time and stored per entry:
  - 001000 addi, 001001 addiu, 100011 lw, 101011 sw -> EOp=00 (sign-extend).
  - 001101 ori -> EOp=01 (zero-extend).
  - 001111 lui -> EOp=10 (imm<<16).
  - 000100 beq -> EOp=11 (sign-extend then <<2).
  - Any other opcode -> EOp=00, illegal=1.
- Occupancy states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions:
  - EMPTY, accept -> ONE; the entry goes to main, and outputs show it in the next cycle (latency 1).
  - ONE, accept and no emit -> FULL; the new entry goes to skid.
  - ONE, accept and emit -> ONE; the new entry replaces main.
  - ONE, emit only -> EMPTY.
  - FULL, emit -> ONE; skid moves to main. No accept is possible because in_ready=0.
  - FULL, no emit -> FULL; all outputs are held stable.
- Output rules:
  - Outputs come straight from the main register; no combinational path from in_* to out_* or from out_ready to in_ready.
  - FIFO order is strictly preserved.
  - While out_valid=1 and out_ready=0, imm, EOp, rt and illegal must not change.
  - When out_valid=0, imm, EOp, rt and illegal hold their last values. The bench must not check them in that state.
- in_valid with in_ready=0 does not count and does not change state. Upstream must hold the word.

Optional Feature:
- Macro: ILLEGAL_DROP_EN.
- Defined:
  - Words with undecodable opcodes are accepted (in_ready handshake completes) but are not written into the buffer.
  - acc_cnt still increments.
  - illegal is tied to 0.
- Undefined: illegal words are buffered and forwarded with illegal=1, as described in Behaviour.

Test Plan:
- Reset check: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, acc_cnt=0. After release, the first accept gives acc_cnt=1.
- Decode sweep, out_ready=1, back-to-back inputs:
  - 0x3C01FFF6 (lui) -> EOp=10, imm=0xFFF6, rt=1.
  - 0x3402FFF6 (ori) -> EOp=01.
  - 0x1000FFF6 (beq) -> EOp=11.
  - 0x2003FFF6 (addi) -> EOp=00, rt=3.
  - Each result appears 1 cycle after accept.
- Backpressure: out_ready=0, send 3 words -> first two accepted, in_ready=0 after the second, third held by upstream. Raising out_ready drains in order; acc_cnt=3 at the end.
- Simultaneous accept and emit in ONE state for 10 cycles -> sustained one word per cycle, no loss or duplication, in_ready stays 1.
- Illegal opcode 0xFC000000 -> without ILLEGAL_DROP_EN, out_valid=1, illegal=1, EOp=00. With ILLEGAL_DROP_EN, no output appears but acc_cnt increments.
- Wrap and mid-op reset: preload acc_cnt to 0xFFFF via 65535 accepts, then accept one more -> acc_cnt=0x0000. Pulse reset while FULL -> both entries lost and out_valid=0 the next cycle.
